// File: rtl/bcd_countdown_ctrl_pkg.sv
// rtl/bcd_countdown_ctrl_pkg.sv - state codes, BCD limit and nibble clamp shared by the countdown controller
package bcd_countdown_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    function automatic logic [3:0] bcd_clamp(input logic [3:0] n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/bcd_countdown_ctrl_if.sv
// rtl/bcd_countdown_ctrl_if.sv - control/status bundle between front-panel logic and the countdown controller
interface bcd_countdown_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] load_val;
    logic                    start;
    logic                    pause;
    logic                    clear;
    logic [4*NUM_DIGITS-1:0] digits;
    logic                    busy;
    logic                    done;
    logic [1:0]              state;

    modport master (
        output load, load_val, start, pause, clear,
        input  digits, busy, done, state
    );

    modport slave (
        input  load, load_val, start, pause, clear,
        output digits, busy, done, state
    );
endinterface

// File: rtl/bcd_countdown_ctrl_digit.sv
// rtl/bcd_countdown_ctrl_digit.sv - one BCD down-counter digit with load and borrow-out
import bcd_countdown_ctrl_pkg::*;

module bcd_down_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] d,
    input  logic       en,
    output logic [3:0] q,
    output logic       bout
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 4'd0;
        end else if (load) begin
            q <= d;
        end else if (en) begin
            q <= (q == 4'd0) ? BCD_MAX : q - 4'd1;
        end
    end

    assign bout = en && (q == 4'd0);

endmodule

// File: rtl/bcd_countdown_ctrl.sv
// rtl/bcd_countdown_ctrl.sv - BCD countdown timer controller: FSM, tick divider, preset and zero detect.
// Optional BCD_COUNTDOWN_AUTO_RELOAD_EN: on zero, reload the preset and keep running.
import bcd_countdown_ctrl_pkg::*;

module bcd_countdown_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 10
) (
    input logic                 clk,
    input logic                 rst,
    bcd_countdown_ctrl_if.slave bus
);

    localparam int                 W        = 4 * NUM_DIGITS;
    localparam int                 DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(TICK_DIV - 1);

    state_t            r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_div, w_div_nxt;
    logic [W-1:0]      r_preset;
    logic              r_busy, r_done, w_busy_nxt, w_done_nxt;
    logic [W-1:0]      w_digits, w_load_clamped, w_dig_d;
    logic [NUM_DIGITS-1:0] w_en, w_bout;
    logic              w_load_acc, w_start_eff, w_pause_eff, w_div_term;
    logic              w_run_tick, w_zero, w_last_tick, w_reload, w_dig_load;
    logic              w_unused_bout;

    assign w_load_acc  = bus.load && !bus.clear && (r_state != ST_RUN);
    assign w_start_eff = bus.start && !bus.pause && !bus.clear && !bus.load;
    assign w_pause_eff = bus.pause && !bus.clear && (r_state == ST_RUN);
    assign w_div_term  = (r_div == DIV_LAST);
    assign w_run_tick  = (r_state == ST_RUN) && !bus.clear && !bus.pause && w_div_term;
    assign w_zero      = (w_digits == '0);
    // Count is never zero in RUN, so a tick at "all digits 0 except digit0==1" lands on zero.
    assign w_last_tick = w_run_tick && (w_digits == W'(1));

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    assign w_reload = w_last_tick && (r_preset != '0);
`else
    assign w_reload = 1'b0;
`endif

    assign w_dig_load = bus.clear || w_load_acc || w_reload;
    assign w_dig_d    = bus.clear ? '0 : (w_load_acc ? w_load_clamped : r_preset);

    genvar k;
    generate
        for (k = 0; k < NUM_DIGITS; k++) begin : g_digit
            assign w_load_clamped[4*k +: 4] = bcd_clamp(bus.load_val[4*k +: 4]);
            if (k == 0) begin : g_lsd
                assign w_en[k] = w_run_tick;
            end else begin : g_upper
                assign w_en[k] = w_bout[k-1];
            end
            bcd_down_digit u_digit (
                .clk  (clk),
                .rst  (rst),
                .load (w_dig_load),
                .d    (w_dig_d[4*k +: 4]),
                .en   (w_en[k]),
                .q    (w_digits[4*k +: 4]),
                .bout (w_bout[k])
            );
        end
    endgenerate

    assign w_unused_bout = w_bout[NUM_DIGITS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.clear || w_load_acc) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (w_start_eff) w_state_nxt = w_zero ? ST_DONE : ST_RUN;
                ST_RUN: begin
                    if (w_pause_eff)                   w_state_nxt = ST_PAUSE;
                    else if (w_last_tick && !w_reload) w_state_nxt = ST_DONE;
                end
                ST_PAUSE: if (w_start_eff) w_state_nxt = ST_RUN;
                default:  w_state_nxt = r_state;
            endcase
        end
    end

    always_comb begin
        w_busy_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_PAUSE);
        w_done_nxt = ((r_state == ST_IDLE) && w_start_eff && w_zero) || w_last_tick;
    end

    always_comb begin
        w_div_nxt = r_div;
        if (bus.clear || w_load_acc || (r_state == ST_IDLE)) begin
            w_div_nxt = '0;
        end else if ((r_state == ST_RUN) && !bus.pause) begin
            w_div_nxt = w_div_term ? '0 : r_div + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div    <= '0;
            r_preset <= '0;
        end else begin
            r_div <= w_div_nxt;
            if (w_load_acc) r_preset <= w_load_clamped;
        end
    end

    assign bus.digits = w_digits;
    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.state  = r_state;

endmodule

// File: tb/tb_bcd_countdown_ctrl.sv
// tb/tb_bcd_countdown_ctrl.sv - self-checking bench for bcd_countdown_ctrl (NUM_DIGITS=2, TICK_DIV=4)
module tb_bcd_countdown_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bcd_countdown_ctrl_if #(.NUM_DIGITS(2)) bus ();

    bcd_countdown_ctrl #(.NUM_DIGITS(2), .TICK_DIV(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic [4:0] ctl;
        logic [7:0] lv;
        int         wait_n;
        logic [7:0] e_dig;
        logic       e_busy;
        logic       e_done;
        logic [1:0] e_st;
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] dig;
        logic       busy;
        logic       done;
        logic [1:0] st;
    } exp_t;

    localparam logic [4:0] NOP = 5'b00000, RST = 5'b10000, CLR = 5'b01000,
                           LD  = 5'b00100, PS  = 5'b00010, ST  = 5'b00001;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic void add(input string n, input logic [4:0] c, input logic [7:0] lv,
                                input int w, input logic [7:0] d, input logic b,
                                input logic dn, input logic [1:0] s);
        vec_t v;
        v.name = n; v.ctl = c; v.lv = lv; v.wait_n = w;
        v.e_dig = d; v.e_busy = b; v.e_done = dn; v.e_st = s;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic [4:0] c, input logic [7:0] lv);
        rst          = c[4];
        bus.clear    = c[3];
        bus.load     = c[2];
        bus.pause    = c[1];
        bus.start    = c[0];
        bus.load_val = lv;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic step(input logic [4:0] c, input logic [7:0] lv, input bit chk, input exp_t e);
        exp_t x;
        drive(c, lv);
        if (chk) sb.push_back(e);
        @(posedge clk);
        #1;
        if (chk) begin
            x = sb.pop_front();
            check({x.name, ".digits"}, 32'(bus.digits), 32'(x.dig));
            check({x.name, ".busy"},   32'(bus.busy),   32'(x.busy));
            check({x.name, ".done"},   32'(bus.done),   32'(x.done));
            check({x.name, ".state"},  32'(bus.state),  32'(x.st));
        end
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        exp_t dummy;
        int   cyc;
        int   extra_done;

        dummy = '{name: "", dig: 8'h00, busy: 1'b0, done: 1'b0, st: 2'd0};
        drive(RST, 8'h00);

`ifndef BCD_COUNTDOWN_AUTO_RELOAD_EN
        add("reset",          RST, 8'h00,  0, 8'h00, 0, 0, 2'd0);
        add("load12",         LD,  8'h12,  0, 8'h12, 0, 0, 2'd0);
        add("start12",        ST,  8'h00,  0, 8'h12, 1, 0, 2'd1);
        add("pre_tick",       NOP, 8'h00,  2, 8'h12, 1, 0, 2'd1);
        add("first_tick",     NOP, 8'h00,  0, 8'h11, 1, 0, 2'd1);
        add("edge47",         NOP, 8'h00, 42, 8'h01, 1, 0, 2'd1);
        add("edge48_zero",    NOP, 8'h00,  0, 8'h00, 0, 1, 2'd3);
        add("done_one_cycle", NOP, 8'h00,  0, 8'h00, 0, 0, 2'd3);
        add("start_in_done",  ST,  8'h00,  3, 8'h00, 0, 0, 2'd3);
        add("load10",         LD,  8'h10,  0, 8'h10, 0, 0, 2'd0);
        add("start10",        ST,  8'h00,  0, 8'h10, 1, 0, 2'd1);
        add("borrow_09",      NOP, 8'h00,  3, 8'h09, 1, 0, 2'd1);
        add("borrow_08",      NOP, 8'h00,  3, 8'h08, 1, 0, 2'd1);
        add("clear_run",      CLR, 8'h00,  0, 8'h00, 0, 0, 2'd0);
        add("load05",         LD,  8'h05,  0, 8'h05, 0, 0, 2'd0);
        add("start05",        ST,  8'h00,  0, 8'h05, 1, 0, 2'd1);
        add("div_to_2",       NOP, 8'h00,  1, 8'h05, 1, 0, 2'd1);
        add("pause_div2",     PS,  8'h00,  0, 8'h05, 1, 0, 2'd2);
        add("frozen20",       NOP, 8'h00, 19, 8'h05, 1, 0, 2'd2);
        add("resume",         ST,  8'h00,  0, 8'h05, 1, 0, 2'd1);
        add("resume_div3",    NOP, 8'h00,  0, 8'h05, 1, 0, 2'd1);
        add("load_in_run",    LD,  8'h99,  0, 8'h04, 1, 0, 2'd1);
        add("to_div3",        NOP, 8'h00,  2, 8'h04, 1, 0, 2'd1);
        add("pause_on_term",  PS,  8'h00,  0, 8'h04, 1, 0, 2'd2);
        add("held_term",      NOP, 8'h00,  3, 8'h04, 1, 0, 2'd2);
        add("resume_term",    ST,  8'h00,  0, 8'h04, 1, 0, 2'd1);
        add("tick_after_res", NOP, 8'h00,  0, 8'h03, 1, 0, 2'd1);
        add("clear2",         CLR, 8'h00,  0, 8'h00, 0, 0, 2'd0);
        add("load00",         LD,  8'h00,  0, 8'h00, 0, 0, 2'd0);
        add("start_zero",     ST,  8'h00,  0, 8'h00, 0, 1, 2'd3);
        add("zero_done_drop", NOP, 8'h00,  0, 8'h00, 0, 0, 2'd3);
        add("clamp_AF",       LD,  8'hAF,  0, 8'h99, 0, 0, 2'd0);
        add("load07",         LD,  8'h07,  0, 8'h07, 0, 0, 2'd0);
        add("start07",        ST,  8'h00,  0, 8'h07, 1, 0, 2'd1);
        add("clear_at07",     CLR, 8'h00,  0, 8'h00, 0, 0, 2'd0);
        add("no_done_clear",  NOP, 8'h00,  5, 8'h00, 0, 0, 2'd0);
        add("start_cleared",  ST,  8'h00,  0, 8'h00, 0, 1, 2'd3);
        add("load30",         LD,  8'h30,  0, 8'h30, 0, 0, 2'd0);
        add("start30",        ST,  8'h00,  0, 8'h30, 1, 0, 2'd1);
        add("borrow_29",      NOP, 8'h00,  3, 8'h29, 1, 0, 2'd1);
        add("rst_in_run",     RST, 8'h00,  0, 8'h00, 0, 0, 2'd0);
        add("after_rst",      NOP, 8'h00,  3, 8'h00, 0, 0, 2'd0);
`else
        add("reset",          RST, 8'h00,  0, 8'h00, 0, 0, 2'd0);
        add("load02",         LD,  8'h02,  0, 8'h02, 0, 0, 2'd0);
        add("start02",        ST,  8'h00,  0, 8'h02, 1, 0, 2'd1);
        add("ar_01",          NOP, 8'h00,  3, 8'h01, 1, 0, 2'd1);
        add("ar_reload",      NOP, 8'h00,  3, 8'h02, 1, 1, 2'd1);
        add("ar_drop",        NOP, 8'h00,  0, 8'h02, 1, 0, 2'd1);
        add("ar_01b",         NOP, 8'h00,  2, 8'h01, 1, 0, 2'd1);
        add("ar_reload2",     NOP, 8'h00,  3, 8'h02, 1, 1, 2'd1);
        add("ar_pause",       PS,  8'h00,  0, 8'h02, 1, 0, 2'd2);
        add("ar_load00",      LD,  8'h00,  0, 8'h00, 0, 0, 2'd0);
        add("ar_start_zero",  ST,  8'h00,  0, 8'h00, 0, 1, 2'd3);
`endif

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            e.name = vecs[i].name;
            e.dig  = vecs[i].e_dig;
            e.busy = vecs[i].e_busy;
            e.done = vecs[i].e_done;
            e.st   = vecs[i].e_st;
            step(vecs[i].ctl, vecs[i].lv, vecs[i].wait_n == 0, e);
            for (int j = 0; j < vecs[i].wait_n; j++)
                step(NOP, 8'h00, j == vecs[i].wait_n - 1, e);
        end

        // Full countdown from 03: done must arrive 12 edges after start and last one cycle.
        step(LD, 8'h03, 1'b0, dummy);
        step(ST, 8'h00, 1'b0, dummy);
        cyc = 0;
        while (!bus.done && cyc < 100) begin
            step(NOP, 8'h00, 1'b0, dummy);
            cyc++;
        end
        check("seq03.latency", 32'(cyc), 32'd12);
`ifndef BCD_COUNTDOWN_AUTO_RELOAD_EN
        check("seq03.digits", 32'(bus.digits), 32'h00);
`else
        check("seq03.digits", 32'(bus.digits), 32'h03);
`endif
        extra_done = 0;
        for (int j = 0; j < 5; j++) begin
            step(NOP, 8'h00, 1'b0, dummy);
            if (bus.done) extra_done++;
        end
        check("seq03.pulse_width", 32'(extra_done), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
